// File: rtl/core19_pkg.sv
// Shared definitions for the 19-bit core: opcodes, control bundle and decoder states.
package core19_pkg;

  localparam int OPC_W = 5;

  localparam logic [OPC_W-1:0] OP_ADD = 5'b00000;
  localparam logic [OPC_W-1:0] OP_SUB = 5'b00001;
  localparam logic [OPC_W-1:0] OP_AND = 5'b00010;
  localparam logic [OPC_W-1:0] OP_OR  = 5'b00011;
  localparam logic [OPC_W-1:0] OP_ADC = 5'b00100;
  localparam logic [OPC_W-1:0] OP_SBC = 5'b00101;
  localparam logic [OPC_W-1:0] OP_XOR = 5'b00110;
  localparam logic [OPC_W-1:0] OP_SHL = 5'b00111;
  localparam logic [OPC_W-1:0] OP_SHR = 5'b01000;
  localparam logic [OPC_W-1:0] OP_NOT = 5'b01001;
  localparam logic [OPC_W-1:0] OP_JMP = 5'b01010;
  localparam logic [OPC_W-1:0] OP_BEQ = 5'b01011;
  localparam logic [OPC_W-1:0] OP_BNE = 5'b01100;
  localparam logic [OPC_W-1:0] OP_LD  = 5'b01111;
  localparam logic [OPC_W-1:0] OP_ST  = 5'b10000;

  typedef struct packed {
    logic [OPC_W-1:0] alu_ctrl;
    logic             pc_src;
    logic             reg_c;
    logic             sbsc;
    logic             reg_we;
    logic             c_we;
    logic             mem_we;
    logic             dc;
    logic             dldm;
    logic             jmp;
  } ctrl_t;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    MEM   = 2'd1,
    FLUSH = 2'd2
  } state_t;

endpackage

// File: rtl/pipelined_decoder_if.sv
// Fetch-side and execute-side handshake plus the registered control bundle.
interface pipelined_decoder_if #(
  parameter int INSTR_W = 19,
  parameter int FLAG_W  = 4
);
  logic               in_valid;
  logic               in_ready;
  logic [INSTR_W-1:0] instr;
  logic [FLAG_W-1:0]  flag;
  logic               out_valid;
  logic               out_ready;
  logic [4:0]         alu_ctrl;
  logic               pc_src;
  logic               reg_c;
  logic               sbsc;
  logic               reg_we;
  logic               c_we;
  logic               mem_we;
  logic               dc;
  logic               dldm;
  logic               jmp;
  logic               flush;
  logic               illegal;

  modport master (
    output in_valid, instr, flag, out_ready,
    input  in_ready, out_valid, alu_ctrl, pc_src, reg_c, sbsc, reg_we,
           c_we, mem_we, dc, dldm, jmp, flush, illegal
  );

  modport slave (
    input  in_valid, instr, flag, out_ready,
    output in_ready, out_valid, alu_ctrl, pc_src, reg_c, sbsc, reg_we,
           c_we, mem_we, dc, dldm, jmp, flush, illegal
  );
endinterface

// File: rtl/pipelined_decoder_decode_lut.sv
// Combinational opcode decode. LD/ST write strobes are reported as their final-cycle value.
module decode_lut
  import core19_pkg::*;
(
  input  logic [OPC_W-1:0] opcode,
  input  logic             zero,
  output ctrl_t            ctrl,
  output logic             illegal,
  output logic             is_mem
);

  always_comb begin
    ctrl    = '0;
    illegal = 1'b0;
    is_mem  = 1'b0;
    case (opcode)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SHL, OP_SHR, OP_NOT: begin
        ctrl.alu_ctrl = opcode;
        ctrl.reg_we   = 1'b1;
      end
      OP_ADC, OP_SBC: begin
        ctrl.alu_ctrl = opcode;
        ctrl.reg_c    = 1'b1;
        ctrl.sbsc     = 1'b1;
        ctrl.reg_we   = 1'b1;
      end
      OP_LD: begin
        ctrl.alu_ctrl = OP_LD;
        ctrl.dldm     = 1'b1;
        ctrl.reg_we   = 1'b1;
        is_mem        = 1'b1;
      end
      OP_ST: begin
        ctrl.alu_ctrl = OP_ST;
        ctrl.sbsc     = 1'b1;
        ctrl.dldm     = 1'b1;
        ctrl.mem_we   = 1'b1;
        is_mem        = 1'b1;
      end
      OP_BEQ, OP_BNE: begin
        // both branches share the compare ALU operation
        ctrl.alu_ctrl = OP_BEQ;
        ctrl.sbsc     = 1'b1;
        ctrl.dldm     = 1'b1;
        ctrl.pc_src   = (opcode == OP_BEQ) ? zero : !zero;
      end
      OP_JMP: begin
        ctrl.alu_ctrl = OP_JMP;
        ctrl.sbsc     = 1'b1;
        ctrl.dldm     = 1'b1;
        ctrl.pc_src   = 1'b1;
        ctrl.jmp      = 1'b1;
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/pipelined_decoder.sv
// Registered, handshaked instruction decoder with LD/ST wait sequencing and branch flush.
//   state | meaning
//   RUN   | normal decode, one bundle per accept
//   MEM   | LD/ST occupying the output stage until the final-cycle strobe is taken
//   FLUSH | one cycle after a taken branch/JMP; offered instruction is dropped
module pipelined_decoder
  import core19_pkg::*;
#(
  parameter int INSTR_W = 19,
  parameter int FLAG_W  = 4,
  parameter int MEM_LAT = 2
) (
  input logic               clk,
  input logic               rst_n,
  pipelined_decoder_if.slave bus
);

  localparam int              CNT_W    = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LAT - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             run_en;
  logic             mem_st;
  ctrl_t            ctrl_q;
  logic             out_valid_q;
  logic             flush_q;
  logic             illegal_q;

  ctrl_t lut_ctrl;
  ctrl_t accept_ctrl;
  logic  lut_illegal;
  logic  lut_mem;
  logic  in_ready;
  logic  accept;
  logic  unused_bits;

  decode_lut u_lut (
    .opcode  (bus.instr[INSTR_W-1 -: OPC_W]),
    .zero    (bus.flag[FLAG_W-1]),
    .ctrl    (lut_ctrl),
    .illegal (lut_illegal),
    .is_mem  (lut_mem)
  );

  assign unused_bits = ^{bus.instr, bus.flag};

  // run_en keeps in_ready low until the first edge after reset release
  assign in_ready = run_en && ((state == FLUSH) ||
                               ((state == RUN) && (!out_valid_q || bus.out_ready)));
  assign accept   = bus.in_valid && in_ready;

  always_comb begin
    accept_ctrl = lut_ctrl;
    if (lut_mem && (CNT_LOAD != '0)) begin
      accept_ctrl.reg_we = 1'b0;
      accept_ctrl.mem_we = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= RUN;
      cnt         <= '0;
      run_en      <= 1'b0;
      mem_st      <= 1'b0;
      ctrl_q      <= '0;
      out_valid_q <= 1'b0;
      flush_q     <= 1'b0;
      illegal_q   <= 1'b0;
    end else begin
      run_en  <= 1'b1;
      flush_q <= 1'b0;
      case (state)
        RUN: begin
          if (accept) begin
            ctrl_q      <= accept_ctrl;
            illegal_q   <= lut_illegal;
            out_valid_q <= 1'b1;
            if (lut_mem) begin
              state  <= MEM;
              cnt    <= CNT_LOAD;
              mem_st <= lut_ctrl.mem_we;
            end else if (lut_ctrl.pc_src) begin
              state   <= FLUSH;
              flush_q <= 1'b1;
            end
          end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            ctrl_q      <= '0;
            illegal_q   <= 1'b0;
          end
        end
        MEM: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
            if (cnt == CNT_W'(1)) begin
              if (mem_st) ctrl_q.mem_we <= 1'b1;
              else        ctrl_q.reg_we <= 1'b1;
            end
          end else if (bus.out_ready) begin
            state       <= RUN;
            out_valid_q <= 1'b0;
            ctrl_q      <= '0;
            illegal_q   <= 1'b0;
          end
        end
        FLUSH: begin
          state <= RUN;
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            ctrl_q      <= '0;
            illegal_q   <= 1'b0;
          end
        end
        default: state <= RUN;
      endcase
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.alu_ctrl  = ctrl_q.alu_ctrl;
  assign bus.pc_src    = ctrl_q.pc_src;
  assign bus.reg_c     = ctrl_q.reg_c;
  assign bus.sbsc      = ctrl_q.sbsc;
  assign bus.reg_we    = ctrl_q.reg_we;
  assign bus.c_we      = ctrl_q.c_we;
  assign bus.mem_we    = ctrl_q.mem_we;
  assign bus.dc        = ctrl_q.dc;
  assign bus.dldm      = ctrl_q.dldm;
  assign bus.jmp       = ctrl_q.jmp;
  assign bus.flush     = flush_q;
  assign bus.illegal   = illegal_q;

endmodule

// File: tb/tb_pipelined_decoder.sv
// Directed bench for pipelined_decoder with MEM_LAT=3 and hand-computed bundles.
module tb_pipelined_decoder;

  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  pipelined_decoder_if #(.INSTR_W(19), .FLAG_W(4)) bus ();

  pipelined_decoder #(.INSTR_W(19), .FLAG_W(4), .MEM_LAT(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  // {alu, pc_src, reg_c, sbsc, reg_we, c_we, mem_we, dc, dldm, jmp, flush, illegal, out_valid}
  function automatic logic [16:0] snap();
    return {bus.alu_ctrl, bus.pc_src, bus.reg_c, bus.sbsc, bus.reg_we, bus.c_we,
            bus.mem_we, bus.dc, bus.dldm, bus.jmp, bus.flush, bus.illegal, bus.out_valid};
  endfunction

  function automatic logic [16:0] mk(input logic [4:0] alu, input logic pc, rc, sb, rw,
                                     mw, dl, jp, fl, il, v);
    return {alu, pc, rc, sb, rw, 1'b0, mw, 1'b0, dl, jp, fl, il, v};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [18:0] ins(input logic [4:0] op);
    return {op, 14'h2a5c};
  endfunction

  localparam logic [16:0] ZERO   = 17'h0;
  localparam logic [16:0] E_ST   = 17'h0;

  initial begin
    logic [4:0] ops [4];
    logic [16:0] e_alu [4];
    logic [16:0] e_st, e_st_w, e_ld, e_ld_w, e_bt, e_bt_held, e_bnt, e_jmp, e_ill;
    ops   = '{5'b00001, 5'b00100, 5'b00110, 5'b01001};
    e_alu = '{mk(5'b00001, 0,0,0,1,0,0,0,0,0,1),
              mk(5'b00100, 0,1,1,1,0,0,0,0,0,1),
              mk(5'b00110, 0,0,0,1,0,0,0,0,0,1),
              mk(5'b01001, 0,0,0,1,0,0,0,0,0,1)};
    e_st      = mk(5'b10000, 0,0,1,0,0,1,0,0,0,1);
    e_st_w    = mk(5'b10000, 0,0,1,0,1,1,0,0,0,1);
    e_ld      = mk(5'b01111, 0,0,0,0,0,1,0,0,0,1);
    e_ld_w    = mk(5'b01111, 0,0,0,1,0,1,0,0,0,1);
    e_bt      = mk(5'b01011, 1,0,1,0,0,1,0,1,0,1);
    e_bt_held = mk(5'b01011, 1,0,1,0,0,1,0,0,0,1);
    e_bnt     = mk(5'b01011, 0,0,1,0,0,1,0,0,0,1);
    e_jmp     = mk(5'b01010, 1,0,1,0,0,1,1,1,0,1);
    e_ill     = mk(5'b00000, 0,0,0,0,0,0,0,0,1,1);

    // 1: reset with ADD offered
    rst_n         = 1'b0;
    bus.in_valid  = 1'b1;
    bus.instr     = ins(5'b00000);
    bus.flag      = 4'b0000;
    bus.out_ready = 1'b1;
    #3;
    chk("rst_outputs", 32'(snap()), 32'(ZERO));
    chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    chk("rel_in_ready_pre", 32'(bus.in_ready), 32'd0);
    tick();
    chk("rel_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rel_no_bundle", 32'(snap()), 32'(ZERO));
    tick();
    chk("first_add", 32'(snap()), 32'(mk(5'b00000, 0,0,0,1,0,0,0,0,0,1)));

    // 2: ALU stream then backpressure
    for (int i = 0; i < 4; i++) begin
      bus.instr = ins(ops[i]);
      tick();
      chk($sformatf("stream%0d", i), 32'(snap()), 32'(e_alu[i]));
      chk($sformatf("stream%0d_rdy", i), 32'(bus.in_ready), 32'd1);
    end
    bus.out_ready = 1'b0;
    bus.instr     = ins(5'b00010);
    #1;
    chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("bp_hold%0d", i), 32'(snap()), 32'(e_alu[3]));
      chk($sformatf("bp_rdy%0d", i), 32'(bus.in_ready), 32'd0);
    end
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b0;
    tick();
    chk("bp_drain", 32'(snap()), 32'(ZERO));

    // 3: ST with MEM_LAT=3, then ST with stall in the last cycle
    bus.in_valid = 1'b1;
    bus.instr    = ins(5'b10000);
    tick();
    bus.in_valid = 1'b0;
    chk("st_c1", 32'(snap()), 32'(e_st));
    chk("st_c1_rdy", 32'(bus.in_ready), 32'd0);
    tick();
    chk("st_c2", 32'(snap()), 32'(e_st));
    tick();
    chk("st_c3", 32'(snap()), 32'(e_st_w));
    chk("st_c3_rdy", 32'(bus.in_ready), 32'd0);
    tick();
    chk("st_done", 32'(snap()), 32'(ZERO));
    chk("st_done_rdy", 32'(bus.in_ready), 32'd1);

    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    chk("st2_c1", 32'(snap()), 32'(e_st));
    tick();
    chk("st2_c2", 32'(snap()), 32'(e_st));
    tick();
    chk("st2_c3", 32'(snap()), 32'(e_st_w));
    bus.out_ready = 1'b0;
    tick();
    chk("st2_hold1", 32'(snap()), 32'(e_st_w));
    tick();
    chk("st2_hold2", 32'(snap()), 32'(e_st_w));
    chk("st2_hold_rdy", 32'(bus.in_ready), 32'd0);
    bus.out_ready = 1'b1;
    tick();
    chk("st2_done", 32'(snap()), 32'(ZERO));

    // 4: BEQ taken with a dropped follower, then BEQ not taken
    bus.in_valid = 1'b1;
    bus.instr    = ins(5'b01011);
    bus.flag     = 4'b1000;
    tick();
    chk("beq_t", 32'(snap()), 32'(e_bt));
    chk("beq_t_flush_rdy", 32'(bus.in_ready), 32'd1);
    bus.instr     = ins(5'b00000);
    bus.flag      = 4'b0000;
    bus.out_ready = 1'b0;
    tick();
    chk("beq_t_held", 32'(snap()), 32'(e_bt_held));
    chk("beq_t_held_rdy", 32'(bus.in_ready), 32'd0);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    chk("beq_t_drain", 32'(snap()), 32'(ZERO));

    bus.in_valid = 1'b1;
    bus.instr    = ins(5'b01011);
    bus.flag     = 4'b0000;
    tick();
    bus.in_valid = 1'b0;
    chk("beq_nt", 32'(snap()), 32'(e_bnt));
    chk("beq_nt_rdy", 32'(bus.in_ready), 32'd1);
    tick();
    chk("beq_nt_drain", 32'(snap()), 32'(ZERO));

    // 5: BNE taken on zero flag clear, BNE not taken, JMP
    bus.in_valid = 1'b1;
    bus.instr    = ins(5'b01100);
    tick();
    bus.in_valid = 1'b0;
    chk("bne_t", 32'(snap()), 32'(e_bt));
    tick();
    chk("bne_t_drain", 32'(snap()), 32'(ZERO));
    bus.in_valid = 1'b1;
    bus.flag     = 4'b1000;
    tick();
    bus.in_valid = 1'b0;
    chk("bne_nt", 32'(snap()), 32'(e_bnt));
    tick();
    bus.in_valid = 1'b1;
    bus.instr    = ins(5'b01010);
    tick();
    bus.in_valid = 1'b0;
    chk("jmp", 32'(snap()), 32'(e_jmp));
    tick();
    chk("jmp_drain", 32'(snap()), 32'(ZERO));

    // 6: illegal opcode, full LD, LD aborted by reset
    bus.in_valid = 1'b1;
    bus.instr    = ins(5'b11111);
    tick();
    bus.in_valid = 1'b0;
    chk("illegal", 32'(snap()), 32'(e_ill));
    chk("illegal_rdy", 32'(bus.in_ready), 32'd1);
    tick();
    bus.in_valid = 1'b1;
    bus.instr    = ins(5'b01111);
    tick();
    bus.in_valid = 1'b0;
    chk("ld_c1", 32'(snap()), 32'(e_ld));
    tick();
    chk("ld_c2", 32'(snap()), 32'(e_ld));
    tick();
    chk("ld_c3", 32'(snap()), 32'(e_ld_w));
    tick();
    chk("ld_done", 32'(snap()), 32'(ZERO));

    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    tick();
    chk("ld2_c2", 32'(snap()), 32'(e_ld));
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_out", 32'(snap()), 32'(ZERO));
    chk("async_rst_rdy", 32'(bus.in_ready), 32'd0);
    #2;
    rst_n = 1'b1;
    tick();
    chk("post_rst_run", 32'(bus.in_ready), 32'd1);
    chk("post_rst_out", 32'(snap()), 32'(ZERO));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
